mem_access_ctrl: RTL

Memory-access stage controller between the EXMEM pipeline register and MEMWB. It turns the load/store request from EX into byte-enabled requests on the data-RAM bus and runs a ready/enable handshake with a variable-latency RAM. It raises a stall request while the access is outstanding and flags misaligned addresses. It also hands the captured read word and the qualified write-back controls to MEMWB.

---
 rtl/mem_access_ctrl_if.sv | 23 ++
 rtl/mem_access_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Data-RAM bus between the memory-access stage (master) and a variable-latency RAM (slave).
// ram_en acts as valid: once raised, ram_addr/ram_write_en/ram_write_data stay stable until a cycle with ram_ready=1 completes it.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ram_en;
  logic [3:0]        ram_write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_write_data;
  logic              ram_ready;
  logic [DATA_W-1:0] ram_read_data;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_ready, ram_read_data
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_ready, ram_read_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues byte-enabled RAM requests, stalls the pipe while one is in flight,
// flags misaligned accesses and forwards the captured read word and write-back controls to MEMWB.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_current_stage,
  input  logic              mem_read_flag_in,
  input  logic              mem_write_flag_in,
  input  logic              mem_sign_ext_flag_in,
  input  logic [3:0]        mem_sel_in,
  input  logic [ADDR_W-1:0] result_in,
  input  logic [DATA_W-1:0] mem_write_data_in,
  input  logic              reg_write_en_in,
  input  logic [4:0]        reg_write_addr_in,
  input  logic [ADDR_W-1:0] current_pc_addr_in,
  mem_access_ctrl_if.master ram,
  output logic              stall_request,
  output logic              addr_error_load,
  output logic              addr_error_store,
  output logic [ADDR_W-1:0] bad_vaddr,
  output logic [DATA_W-1:0] ram_read_data_out,
  output logic              mem_read_flag_out,
  output logic              mem_write_flag_out,
  output logic              mem_sign_ext_flag_out,
  output logic [3:0]        mem_sel_out,
  output logic [ADDR_W-1:0] result_out,
  output logic              reg_write_en_out,
  output logic [4:0]        reg_write_addr_out,
  output logic [ADDR_W-1:0] current_pc_addr_out,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        strobe_q, strobe_d;
  logic              is_read_q, is_read_d;

  logic              access, misaligned, mis_err, aligned_access;
  logic [3:0]        shifted_sel, req_strobe;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              bus_en, bus_stall;
  logic [3:0]        bus_strobe;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;

  assign access         = (mem_read_flag_in | mem_write_flag_in) & ~flush;
  assign misaligned     = ((mem_sel_in == 4'b0011) && result_in[0]) ||
                          ((mem_sel_in == 4'b1111) && (result_in[1:0] != 2'b00));
  assign mis_err        = access & misaligned;
  assign aligned_access = access & ~misaligned;
  assign shifted_sel    = mem_sel_in << result_in[1:0];
  assign req_strobe     = mem_write_flag_in ? shifted_sel : 4'b0000;
  assign req_addr       = {result_in[ADDR_W-1:2], 2'b00};

  always_comb begin
    req_wdata = mem_write_data_in;
    case (mem_sel_in)
      4'b0001: req_wdata = {(DATA_W/8){mem_write_data_in[7:0]}};
      4'b0011: req_wdata = {(DATA_W/16){mem_write_data_in[15:0]}};
      default: req_wdata = mem_write_data_in;
    endcase
  end

  // IDLE drives the bus straight from EXMEM; WAIT/DRAIN replay the latched copy so a
  // flushed or changing EXMEM cannot disturb a request the RAM is still working on.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strobe_d   = strobe_q;
    is_read_d  = is_read_q;
    rdata_d    = rdata_q;
    bus_en     = 1'b0;
    bus_stall  = 1'b0;
    bus_strobe = 4'b0000;
    bus_addr   = req_addr;
    bus_wdata  = req_wdata;
    case (state_q)
      S_IDLE: begin
        if (aligned_access) begin
          bus_en     = 1'b1;
          bus_stall  = 1'b1;
          bus_strobe = req_strobe;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          strobe_d   = req_strobe;
          is_read_d  = mem_read_flag_in;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        bus_en     = 1'b1;
        bus_stall  = 1'b1;
        bus_strobe = strobe_q;
        bus_addr   = addr_q;
        bus_wdata  = wdata_q;
        if (ram.ram_ready) begin
          if (is_read_q && !flush) rdata_d = ram.ram_read_data;
          state_d = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush || !stall_current_stage) state_d = S_IDLE;
      end
      S_DRAIN: begin
        bus_en     = 1'b1;
        bus_stall  = 1'b1;
        bus_strobe = strobe_q;
        bus_addr   = addr_q;
        bus_wdata  = wdata_q;
        if (ram.ram_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strobe_q  <= 4'b0000;
      is_read_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strobe_q  <= strobe_d;
      is_read_q <= is_read_d;
      rdata_q   <= rdata_d;
    end
  end

  // Reset gates the combinational request path too, so it drops the bus without waiting for a clock.
  assign ram.ram_en         = bus_en & ~rst;
  assign ram.ram_write_en   = (bus_en & ~rst) ? bus_strobe : 4'b0000;
  assign ram.ram_addr       = bus_addr;
  assign ram.ram_write_data = bus_wdata;
  assign stall_request      = bus_stall & ~rst;

  assign addr_error_load       = mis_err & mem_read_flag_in;
  assign addr_error_store      = mis_err & mem_write_flag_in;
  assign bad_vaddr             = result_in;
  assign ram_read_data_out     = rdata_q;
  assign mem_read_flag_out     = mem_read_flag_in & ~mis_err;
  assign mem_write_flag_out    = mem_write_flag_in & ~mis_err;
  assign mem_sign_ext_flag_out = mem_sign_ext_flag_in;
  assign mem_sel_out           = mem_sel_in;
  assign result_out            = result_in;
  assign reg_write_en_out      = reg_write_en_in & ~mis_err;
  assign reg_write_addr_out    = reg_write_addr_in;
  assign current_pc_addr_out   = current_pc_addr_in;
  assign dbg_state             = state_q;

endmodule
